// File: rtl/systolic_array_sequencer_if.sv
// Row-addressed load request bus between the memory side and the systolic array sequencer.
interface systolic_array_sequencer_if #(
   parameter int unsigned ARRAY_DIM = 4
);
   logic                         weight_en;
   logic                         input_en;
   logic                         partial_en;
   logic [$clog2(ARRAY_DIM)-1:0] row_en;
   logic                         fifo_has_space;

   modport master (
      output weight_en, input_en, partial_en, row_en,
      input  fifo_has_space
   );

   modport slave (
      input  weight_en, input_en, partial_en, row_en,
      output fifo_has_space
   );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Load/compute sequencer for the weight-stationary systolic array: collects a full tile of
// row loads, then steps MAC start/count/FIFO shift through one pass and tags exiting rows.
module systolic_array_sequencer #(
   parameter int unsigned ARRAY_DIM = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned MAC_LAT   = 3
) (
   input  logic                         CLK,
   input  logic                         nRST,
   systolic_array_sequencer_if.slave    ld,
   output logic                         input_type,
   output logic                         weight_load,
   output logic [$clog2(ARRAY_DIM)-1:0] weight_row,
   output logic                         input_load,
   output logic [$clog2(ARRAY_DIM)-1:0] input_row,
   output logic                         partials_load,
   output logic [$clog2(ARRAY_DIM)-1:0] partials_row,
   output logic                         MAC_start,
   output logic                         MAC_count,
   output logic                         fifo_shift,
   output logic                         out_valid,
   output logic [$clog2(ARRAY_DIM)-1:0] row_out,
   output logic                         pass_done
);
   localparam int unsigned ROW_W     = $clog2(ARRAY_DIM);
   localparam int unsigned NUM_STEPS = 3 * ARRAY_DIM - 2;
   localparam int unsigned STEP_W    = $clog2(NUM_STEPS);
   localparam int unsigned OUT_FIRST = 2 * ARRAY_DIM - 2;
   localparam int unsigned LAT_W     = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

   localparam logic [1:0] LOAD  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] COUNT = 2'd2;
   localparam logic [1:0] SHIFT = 2'd3;

   if (DATA_W == 0 || ARRAY_DIM < 2 || MAC_LAT < 1) begin : g_bad_param
      $error("systolic_array_sequencer: illegal parameter set");
   end

   logic [1:0]           state, state_d;
   logic [STEP_W-1:0]    step, step_d;
   logic [LAT_W-1:0]     lat, lat_d;
   logic [ARRAY_DIM-1:0] wmask, wmask_d, imask, imask_d, pmask, pmask_d;

   logic             fifo_has_space_d, input_type_d, weight_load_d, input_load_d, partials_load_d;
   logic             mac_start_d, mac_count_d, fifo_shift_d, out_valid_d, pass_done_d;
   logic [ROW_W-1:0] weight_row_d, input_row_d, partials_row_d, row_out_d;

   // Next state, counters, masks and the output values they imply for the next cycle.
   always_comb begin
      state_d          = state;
      step_d           = step;
      lat_d            = lat;
      wmask_d          = wmask;
      imask_d          = imask;
      pmask_d          = pmask;
      weight_load_d    = 1'b0;
      weight_row_d     = '0;
      input_load_d     = 1'b0;
      input_row_d      = '0;
      partials_load_d  = 1'b0;
      partials_row_d   = '0;
      fifo_has_space_d = 1'b0;
      mac_start_d      = 1'b0;
      mac_count_d      = 1'b0;
      fifo_shift_d     = 1'b0;
      out_valid_d      = 1'b0;
      row_out_d        = '0;
      pass_done_d      = 1'b0;

      case (state)
         LOAD: begin
            if (ld.weight_en) begin
               weight_load_d        = 1'b1;
               weight_row_d         = ld.row_en;
               wmask_d[ld.row_en]   = 1'b1;
            end else if (ld.input_en) begin
               input_load_d         = 1'b1;
               input_row_d          = ld.row_en;
               imask_d[ld.row_en]   = 1'b1;
            end else if (ld.partial_en) begin
               partials_load_d      = 1'b1;
               partials_row_d       = ld.row_en;
               pmask_d[ld.row_en]   = 1'b1;
            end
            if (&wmask && &imask && &pmask) state_d = START;
         end
         START: begin
            state_d = COUNT;
            lat_d   = '0;
         end
         COUNT: begin
            if (lat == LAT_W'(MAC_LAT - 1)) state_d = SHIFT;
            else                            lat_d   = lat + 1'b1;
         end
         SHIFT: begin
            if (step == STEP_W'(NUM_STEPS - 1)) begin
               step_d  = '0;
               wmask_d = '0;
               imask_d = '0;
               pmask_d = '0;
               state_d = LOAD;
            end else begin
               step_d  = step + 1'b1;
               state_d = START;
            end
         end
         default: state_d = LOAD;
      endcase

      input_type_d     = weight_load_d;
      fifo_has_space_d = (state_d == LOAD);
      mac_start_d      = (state_d == START);
      mac_count_d      = (state_d == COUNT);
      // Step only advances when leaving SHIFT, so it still names the step being shifted out.
      if (state_d == SHIFT) begin
         fifo_shift_d = 1'b1;
         pass_done_d  = (step == STEP_W'(NUM_STEPS - 1));
         if (step >= STEP_W'(OUT_FIRST)) begin
            out_valid_d = 1'b1;
            row_out_d   = ROW_W'(step - STEP_W'(OUT_FIRST));
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state             <= LOAD;
         step              <= '0;
         lat               <= '0;
         wmask             <= '0;
         imask             <= '0;
         pmask             <= '0;
         ld.fifo_has_space <= 1'b0;
         input_type        <= 1'b0;
         weight_load       <= 1'b0;
         weight_row        <= '0;
         input_load        <= 1'b0;
         input_row         <= '0;
         partials_load     <= 1'b0;
         partials_row      <= '0;
         MAC_start         <= 1'b0;
         MAC_count         <= 1'b0;
         fifo_shift        <= 1'b0;
         out_valid         <= 1'b0;
         row_out           <= '0;
         pass_done         <= 1'b0;
      end else begin
         state             <= state_d;
         step              <= step_d;
         lat               <= lat_d;
         wmask             <= wmask_d;
         imask             <= imask_d;
         pmask             <= pmask_d;
         ld.fifo_has_space <= fifo_has_space_d;
         input_type        <= input_type_d;
         weight_load       <= weight_load_d;
         weight_row        <= weight_row_d;
         input_load        <= input_load_d;
         input_row         <= input_row_d;
         partials_load     <= partials_load_d;
         partials_row      <= partials_row_d;
         MAC_start         <= mac_start_d;
         MAC_count         <= mac_count_d;
         fifo_shift        <= fifo_shift_d;
         out_valid         <= out_valid_d;
         row_out           <= row_out_d;
         pass_done         <= pass_done_d;
      end
   end
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer: loads, collisions, pass timing, mid-pass reset.
module tb_systolic_array_sequencer;
   localparam int unsigned D  = 4;
   localparam int unsigned RW = 2;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          input_type, weight_load, input_load, partials_load;
   logic [RW-1:0] weight_row, input_row, partials_row, row_out;
   logic          MAC_start, MAC_count, fifo_shift, out_valid, pass_done;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   systolic_array_sequencer_if #(.ARRAY_DIM(D)) ld ();

   systolic_array_sequencer #(.ARRAY_DIM(D), .DATA_W(16), .MAC_LAT(3)) dut (
      .CLK(CLK), .nRST(nRST), .ld(ld),
      .input_type(input_type),
      .weight_load(weight_load),     .weight_row(weight_row),
      .input_load(input_load),       .input_row(input_row),
      .partials_load(partials_load), .partials_row(partials_row),
      .MAC_start(MAC_start), .MAC_count(MAC_count), .fifo_shift(fifo_shift),
      .out_valid(out_valid), .row_out(row_out), .pass_done(pass_done)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // kind: 0 = weight, 1 = input, 2 = partial
   task automatic do_load(input int kind, input int row);
      ld.weight_en  = (kind == 0);
      ld.input_en   = (kind == 1);
      ld.partial_en = (kind == 2);
      ld.row_en     = RW'(row);
      tick();
      ld.weight_en  = 1'b0;
      ld.input_en   = 1'b0;
      ld.partial_en = 1'b0;
      chk("weight_load", 32'(weight_load),   32'(kind == 0));
      chk("input_load",  32'(input_load),    32'(kind == 1));
      chk("part_load",   32'(partials_load), 32'(kind == 2));
      chk("input_type",  32'(input_type),    32'(kind == 0));
      if (kind == 0) chk("weight_row", 32'(weight_row),   32'(row));
      if (kind == 1) chk("input_row",  32'(input_row),    32'(row));
      if (kind == 2) chk("part_row",   32'(partials_row), 32'(row));
   endtask

   task automatic idle_no_start(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk("no_mac_start", 32'(MAC_start), 32'd0);
      end
   endtask

   task automatic load_tile();
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < 4; r++) do_load(k, r);
      chk("start_not_early", 32'(MAC_start), 32'd0);
      tick();
      chk("start_2_after", 32'(MAC_start), 32'd1);
   endtask

   // Entered on the cycle MAC_start is high; runs until pass_done or a 200-cycle bound.
   task automatic run_pass(input bit poke);
      int  shifts = 0;
      int  run    = 0;
      int  len    = 1;
      bit  done   = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         if (poke) begin
            ld.input_en = (i % 2 == 0);
            ld.row_en   = RW'(i);
         end
         tick();
         len++;
         if (MAC_count) run++;
         chk("space_busy", 32'(ld.fifo_has_space), 32'd0);
         if (poke) chk("ignored_load", 32'(input_load), 32'd0);
         if (fifo_shift) begin
            shifts++;
            chk("count_len", 32'(run), 32'd3);
            run = 0;
            chk("out_valid", 32'(out_valid), 32'(shifts >= 7));
            chk("row_out",   32'(row_out),   32'((shifts >= 7) ? shifts - 7 : 0));
            chk("pass_done", 32'(pass_done), 32'(shifts == 10));
            if (pass_done) done = 1'b1;
         end else begin
            chk("done_off_shift", 32'(pass_done), 32'd0);
         end
      end
      ld.input_en = 1'b0;
      chk("pass_timeout", 32'(done),   32'd1);
      chk("shift_count",  32'(shifts), 32'd10);
      chk("pass_len",     32'(len),    32'd50);
      tick();
      chk("space_after", 32'(ld.fifo_has_space), 32'd1);
   endtask

   initial begin
      nRST          = 1'b0;
      ld.weight_en  = 1'b0;
      ld.input_en   = 1'b0;
      ld.partial_en = 1'b0;
      ld.row_en     = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_space",   32'(ld.fifo_has_space), 32'd0);
      chk("rst_start",   32'(MAC_start),         32'd0);
      chk("rst_wload",   32'(weight_load),       32'd0);
      chk("rst_shift",   32'(fifo_shift),        32'd0);
      nRST = 1'b1;
      tick();
      chk("space_idle", 32'(ld.fifo_has_space), 32'd1);

      // First full pass.
      load_tile();
      run_pass(1'b0);

      // Back-to-back: weights must be refilled; loads during compute are ignored.
      for (int k = 1; k < 3; k++)
         for (int r = 0; r < 4; r++) do_load(k, r);
      idle_no_start(4);
      for (int r = 0; r < 4; r++) do_load(0, r);
      tick();
      chk("start_pass2", 32'(MAC_start), 32'd1);
      run_pass(1'b1);

      // Reset while in COUNT.
      load_tile();
      tick();
      tick();
      chk("in_count", 32'(MAC_count), 32'd1);
      nRST = 1'b0;
      #1;
      chk("mid_rst_count", 32'(MAC_count),         32'd0);
      chk("mid_rst_start", 32'(MAC_start),         32'd0);
      chk("mid_rst_space", 32'(ld.fifo_has_space), 32'd0);
      #2;
      nRST = 1'b1;
      tick();
      chk("space_rel", 32'(ld.fifo_has_space), 32'd1);
      do_load(0, 0);
      idle_no_start(4);

      // Collision on row 2: only the weight load wins.
      ld.weight_en  = 1'b1;
      ld.input_en   = 1'b1;
      ld.partial_en = 1'b1;
      ld.row_en     = 2'd2;
      tick();
      ld.weight_en  = 1'b0;
      ld.input_en   = 1'b0;
      ld.partial_en = 1'b0;
      chk("col_wload", 32'(weight_load),   32'd1);
      chk("col_wrow",  32'(weight_row),    32'd2);
      chk("col_type",  32'(input_type),    32'd1);
      chk("col_iload", 32'(input_load),    32'd0);
      chk("col_pload", 32'(partials_load), 32'd0);

      // Duplicate input row 1, input row 3 and partial row 2 missing.
      do_load(0, 1);
      do_load(0, 3);
      do_load(1, 0);
      do_load(1, 1);
      do_load(1, 1);
      do_load(1, 2);
      do_load(2, 0);
      do_load(2, 1);
      do_load(2, 3);
      idle_no_start(4);
      do_load(2, 2);
      idle_no_start(4);
      do_load(1, 3);
      chk("start_not_early3", 32'(MAC_start), 32'd0);
      tick();
      chk("start_pass3", 32'(MAC_start), 32'd1);
      run_pass(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
